// File: rtl/hex_count_4digit.sv
// Four-digit hex up/down counter with start/stop button,
// clear, load and a wrap pulse; digits drive 7-seg decoders.
module hex_count_4digit #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        running,
  output logic        wrap
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [25:0] PRE_MAX = 26'(TICK_DIV - 1);

  state_t      state;
  state_t      state_n;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        v1;
  logic        v2;
  logic        armed;
  logic        ss_pulse;
  logic        tick;
  logic        wrap_n;
  logic [25:0] pre;
  logic [25:0] pre_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;

  // Synchronize the button, detect rising edges; armed only after
  // a genuine low has been seen so a level held through reset
  // cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= start_stop;
      s2    <= s1;
      s3    <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & ~s2);
    end
  end

  assign ss_pulse = armed & s2 & ~s3;
  assign tick     = (state == RUN) && (pre == PRE_MAX);

  // Next-state, prescaler and count update with clear > load > tick.
  always_comb begin
    state_n = state;
    pre_n   = pre + 26'd1;
    cnt_n   = cnt;
    wrap_n  = 1'b0;
    if (ss_pulse) begin
      state_n = (state == RUN) ? STOP : RUN;
    end
    if (clear || load || tick ||
        state != RUN || state_n != RUN) begin
      pre_n = 26'd0;
    end
    if (clear) begin
      cnt_n = 16'h0000;
    end else if (load) begin
      cnt_n = load_val;
    end else if (tick) begin
      if (up) begin
        cnt_n  = cnt + 16'd1;
        wrap_n = (cnt == 16'hFFFF);
      end else begin
        cnt_n  = cnt - 16'd1;
        wrap_n = (cnt == 16'h0000);
      end
    end
  end

  // State, prescaler, count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STOP;
      running <= 1'b0;
      pre     <= 26'd0;
      cnt     <= 16'h0000;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      pre     <= pre_n;
      cnt     <= cnt_n;
      wrap    <= wrap_n;
    end
  end

  assign digit3 = cnt[15:12];
  assign digit2 = cnt[11:8];
  assign digit1 = cnt[7:4];
  assign digit0 = cnt[3:0];

endmodule

// File: tb/tb_hex_count_4digit.sv
// Bench for hex_count_4digit with TICK_DIV=4: scoreboard queue
// of expected outputs plus a table of STOP-mode clear/load vectors.
module tb_hex_count_4digit;

  logic        clk;
  logic        rst_n;
  logic        start_stop;
  logic        up;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  digit3;
  logic [3:0]  digit2;
  logic [3:0]  digit1;
  logic [3:0]  digit0;
  logic        running;
  logic        wrap;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        run;
    logic        wr;
  } exp_t;

  typedef struct {
    logic        clr;
    logic        ld;
    logic [15:0] val;
    logic [15:0] exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];

  hex_count_4digit #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_stop(start_stop),
    .up(up),
    .clear(clear),
    .load(load),
    .load_val(load_val),
    .digit3(digit3),
    .digit2(digit2),
    .digit1(digit1),
    .digit0(digit0),
    .running(running),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [15:0] c,
                      input logic r, input logic w);
    exp_t e;
    e.name = n;
    e.cnt  = c;
    e.run  = r;
    e.wr   = w;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [15:0] act;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: no expected entry");
      return;
    end
    e = q.pop_front();
    act = {digit3, digit2, digit1, digit0};
    if (act !== e.cnt || running !== e.run || wrap !== e.wr) begin
      failures++;
      $display("FAIL %s: got cnt=%h running=%b wrap=%b, want cnt=%h running=%b wrap=%b",
               e.name, act, running, wrap, e.cnt, e.run, e.wr);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    tbl[0] = '{clr: 1'b0, ld: 1'b1, val: 16'hABCD, exp: 16'hABCD};
    tbl[1] = '{clr: 1'b0, ld: 1'b0, val: 16'hFFFF, exp: 16'hABCD};
    tbl[2] = '{clr: 1'b1, ld: 1'b0, val: 16'h5555, exp: 16'h0000};
    tbl[3] = '{clr: 1'b0, ld: 1'b1, val: 16'hFFFF, exp: 16'hFFFF};
    tbl[4] = '{clr: 1'b1, ld: 1'b1, val: 16'h1234, exp: 16'h0000};
    tbl[5] = '{clr: 1'b0, ld: 1'b1, val: 16'h0001, exp: 16'h0001};

    rst_n      = 1'b0;
    start_stop = 1'b0;
    up         = 1'b1;
    clear      = 1'b0;
    load       = 1'b0;
    load_val   = 16'h0000;

    // reset state
    push("reset", 16'h0000, 1'b0, 1'b0);
    step();
    step();
    check();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // start: running on the 3rd edge after the button rises
    start_stop = 1'b1;
    push("start_e1", 16'h0000, 1'b0, 1'b0);
    step();
    check();
    push("start_e2", 16'h0000, 1'b0, 1'b0);
    step();
    check();
    push("start_e3", 16'h0000, 1'b1, 1'b0);
    step();
    check();
    start_stop = 1'b0;

    // count up, one step every 4 cycles
    for (int i = 1; i <= 40; i++) begin
      push("up_count", 16'(i / 4), 1'b1, 1'b0);
      step();
      check();
    end

    // load FFFE while running, wrap to 0000
    load     = 1'b1;
    load_val = 16'hFFFE;
    push("load_fffe", 16'hFFFE, 1'b1, 1'b0);
    step();
    load = 1'b0;
    check();
    for (int i = 1; i <= 10; i++) begin
      push("up_wrap", 16'(32'hFFFE + i / 4), 1'b1, i == 8);
      step();
      check();
    end

    // clear while running, count down through wrap
    clear = 1'b1;
    up    = 1'b0;
    push("clear_run", 16'h0000, 1'b1, 1'b0);
    step();
    clear = 1'b0;
    check();
    for (int i = 1; i <= 5; i++) begin
      push("down_wrap", 16'(0 - i / 4), 1'b1, i == 4);
      step();
      check();
    end

    // clear has priority over load
    clear    = 1'b1;
    load     = 1'b1;
    load_val = 16'h1234;
    push("clear_and_load", 16'h0000, 1'b1, 1'b0);
    step();
    clear = 1'b0;
    load  = 1'b0;
    check();

    load     = 1'b1;
    load_val = 16'h5A5A;
    up       = 1'b1;
    push("load_5a5a", 16'h5A5A, 1'b1, 1'b0);
    step();
    load = 1'b0;
    check();

    // stop with a held button: exactly one toggle
    start_stop = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      push("stop_held", 16'h5A5A, i < 3, 1'b0);
      step();
      check();
    end
    start_stop = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      push("frozen", 16'h5A5A, 1'b0, 1'b0);
      step();
      check();
    end

    // clear/load table in STOP
    for (int i = 0; i < 6; i++) begin
      clear    = tbl[i].clr;
      load     = tbl[i].ld;
      load_val = tbl[i].val;
      push("stop_table", tbl[i].exp, 1'b0, 1'b0);
      step();
      clear = 1'b0;
      load  = 1'b0;
      check();
    end

    // coincident start and load on the same edge
    start_stop = 1'b1;
    step();
    step();
    load     = 1'b1;
    load_val = 16'h00F0;
    push("start_with_load", 16'h00F0, 1'b1, 1'b0);
    step();
    load       = 1'b0;
    start_stop = 1'b0;
    check();
    for (int i = 1; i <= 4; i++) begin
      push("after_coincident", 16'(32'h00F0 + i / 4), 1'b1, 1'b0);
      step();
      check();
    end

    // asynchronous reset between edges, button held high through it
    step();
    #2;
    rst_n      = 1'b0;
    start_stop = 1'b1;
    #1;
    push("async_reset", 16'h0000, 1'b0, 1'b0);
    check();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push("held_after_reset", 16'h0000, 1'b0, 1'b0);
      step();
      check();
    end

    // release and press again: now it starts
    start_stop = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start_stop = 1'b1;
    push("repress_e2", 16'h0000, 1'b0, 1'b0);
    step();
    step();
    check();
    push("repress_e3", 16'h0000, 1'b1, 1'b0);
    step();
    check();
    start_stop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_count_4digit.md
HEX_COUNT_4DIGIT -- requirements
Module: hex_count_4digit

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per count tick (legal range 2 to 2^26).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start_stop, input, 1 bit: asynchronous push-button level; each rising edge toggles run/stop.
REQ-005 SHALL have port up, input, 1 bit: count direction (1 = increment, 0 = decrement), sampled on each tick.
REQ-006 SHALL have port clear, input, 1 bit: synchronous, zeroes the count.
REQ-007 SHALL have port load, input, 1 bit: synchronous, loads load_val into the count.
REQ-008 SHALL have port load_val, input, 16 bits: value used by load.
REQ-009 SHALL have ports digit3, digit2, digit1, digit0, output, 4 bits each: count nibbles, MSN to LSN, each feeding one 7-segment decoder.
REQ-010 SHALL have port running, output, 1 bit: high while the FSM is in RUN.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on count wrap-around.

Function
REQ-012 SHALL pass start_stop through a 2-flop synchronizer, then a rising-edge detector, producing a one-cycle pulse ss_pulse.
REQ-013 SHALL assert ss_pulse on the 3rd rising clk edge after start_stop rises (2 sync stages + edge register); a held level SHALL produce only one pulse.
REQ-014 SHALL implement a 2-state FSM: STOP (reset state) and RUN.
REQ-015 SHALL transition STOP->RUN and RUN->STOP on ss_pulse; otherwise the state holds.
REQ-016 SHALL keep a prescaler pre[25:0] that is held at 0 in STOP and counts 0..TICK_DIV-1 in RUN, wrapping to 0.
REQ-017 SHALL define tick as (state==RUN && pre==TICK_DIV-1); the count updates on the same edge that wraps pre to 0.
REQ-018 SHALL make the first tick after entering RUN occur exactly TICK_DIV cycles after the STOP->RUN edge.
REQ-019 SHALL hold the count as cnt[15:0], with digit3=cnt[15:12], digit2=cnt[11:8], digit1=cnt[7:4], digit0=cnt[3:0], all registered, no combinational path from inputs.
REQ-020 SHALL on tick with up=1 set cnt <= cnt+1 modulo 2^16, and on tick with up=0 set cnt <= cnt-1 modulo 2^16.
REQ-021 SHALL pulse wrap for exactly one cycle, the cycle after the edge where cnt goes FFFF->0000 (up) or 0000->FFFF (down); no other transition asserts wrap.
REQ-022 SHALL apply priority per cycle: clear > load > tick; clear or load SHALL also reset pre to 0 and suppress wrap.
REQ-023 SHALL honour clear and load in both STOP and RUN; neither changes the FSM state.
REQ-024 SHALL act on both a coincident ss_pulse and clear/load: the state toggles and cnt clears/loads on the same edge.
REQ-025 SHALL make running a registered copy of (state==RUN).

Reset
REQ-026 SHALL on rst_n low immediately force state=STOP, pre=0, cnt=0000, wrap=0, running=0, and clear the synchronizer and edge flops, independent of clk.
REQ-027 SHALL, after rst_n deasserts with start_stop already high, not generate ss_pulse until start_stop falls and rises again.
REQ-028 SHALL, if reset asserts mid-RUN, resume in STOP with count 0000 on release.

Verification (TICK_DIV=4)
REQ-029 SHALL test: reset, pulse start_stop, up=1 for 40 cycles -> running=1 at cycle 3; digit0 increments every 4 cycles; first change 4 cycles after the RUN edge.
REQ-030 SHALL test: load with load_val=FFFE, RUN, up=1 -> count reaches FFFF, then 0000, with wrap high for one cycle only at the 0000 step.
REQ-031 SHALL test: clear while RUN, up=0 -> count 0000, then after 4 cycles FFFF with a wrap pulse; clear and load both high with load_val=1234 -> 0000.
REQ-032 SHALL test: second start_stop pulse -> running=0 and the count freezes for 100 cycles; start_stop held high for 50 cycles -> exactly one toggle.
REQ-033 SHALL test: rst_n low mid-count (between clk edges) -> all outputs 0 immediately, state STOP after release.
